// File: rtl/i2s_pkg.sv
// Shared defaults and slot-position constants for the I2S transmitter.
package i2s_pkg;

  localparam int unsigned CLK_DIV_DEF = 8;
  localparam int unsigned SMPL_W_DEF  = 24;
  localparam int unsigned SLOT_W_DEF  = 32;

  // Slot positions of the word's MSB and LSB (position 0 is the one-bit I2S delay).
  localparam int unsigned P_MSB = 1;
  localparam int unsigned P_LSB = SMPL_W_DEF;

  typedef enum logic {
    ChLeft  = 1'b0,
    ChRight = 1'b1
  } chan_e;

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit-clock divider: toggles sclk every CLK_DIV clk cycles and flags the
// falling/rising transitions one cycle ahead so callers update in the same edge.
module i2s_clk_gen #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_sclk,
  output logic o_fall,
  output logic o_rise
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] r_div_cnt;
  logic            r_sclk;
  logic            w_wrap;

  assign w_wrap = (r_div_cnt == CntW'(CLK_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
    end else if (w_wrap) begin
      r_div_cnt <= '0;
      r_sclk    <= ~r_sclk;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign o_sclk = r_sclk;
  assign o_fall = w_wrap & r_sclk;
  assign o_rise = w_wrap & ~r_sclk;

endmodule

// File: rtl/i2s_tx.sv
// Master-mode I2S transmitter: L/R holding registers with fresh/overrun tracking,
// frame-aligned load into per-channel shifters, and registered sclk/lrclk/sdata.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF,
  parameter int unsigned SMPL_W  = SMPL_W_DEF,
  parameter int unsigned SLOT_W  = SLOT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_din_valid,
  input  logic [SMPL_W-1:0] i_din,
  output logic              o_sclk,
  output logic              o_lrclk,
  output logic              o_sdata,
  output logic              o_frame_start,
  output logic              o_underrun,
  output logic              o_overrun
);

  localparam int unsigned FrameBits = 2 * SLOT_W;
  localparam int unsigned BitW      = $clog2(FrameBits);

  logic              w_fall;
  logic              w_rise_unused;
  logic [BitW-1:0]   r_bit_cnt;
  logic [BitW-1:0]   w_bit_nxt;
  logic [BitW-1:0]   w_pos;
  chan_e             w_chan_nxt;
  logic              w_load;
  logic              w_in_word;
  logic              w_sdata_nxt;
  logic              w_wr_l;
  logic              w_wr_r;
  logic [SMPL_W-1:0] r_hold_l;
  logic [SMPL_W-1:0] r_hold_r;
  logic              r_fresh_l;
  logic              r_fresh_r;
  logic [SMPL_W-1:0] r_shift_l;
  logic [SMPL_W-1:0] r_shift_r;
  logic              r_lsb_l;
  logic              r_lsb_r;
  logic              r_lrclk;
  logic              r_sdata;
  logic              r_frame_start;
  logic              r_underrun;
  logic              r_overrun;

  i2s_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .o_sclk(o_sclk),
    .o_fall(w_fall),
    .o_rise(w_rise_unused)
  );

  assign w_bit_nxt  = (r_bit_cnt == BitW'(FrameBits - 1)) ? '0 : r_bit_cnt + 1'b1;
  assign w_chan_nxt = (w_bit_nxt >= BitW'(SLOT_W)) ? ChRight : ChLeft;
  assign w_pos      = (w_chan_nxt == ChRight) ? w_bit_nxt - BitW'(SLOT_W) : w_bit_nxt;
  assign w_load     = w_fall && (r_bit_cnt == BitW'(FrameBits - 1));
  assign w_in_word  = (w_pos >= BitW'(P_MSB)) && (w_pos <= BitW'(SMPL_W));

  // Illegal 2'b11 falls through to the left write only.
  assign w_wr_l = i_din_valid[0];
  assign w_wr_r = (i_din_valid == 2'b10);

  // Position 0 carries the LSB of the word sent in the preceding slot; at the frame
  // load edge r_lsb_r still holds the previous frame's right LSB.
  always_comb begin
    w_sdata_nxt = 1'b0;
    if (w_pos == '0) begin
      w_sdata_nxt = (w_chan_nxt == ChRight) ? r_lsb_l : r_lsb_r;
    end else if (w_in_word) begin
      w_sdata_nxt = (w_chan_nxt == ChRight) ? r_shift_r[SMPL_W-1] : r_shift_l[SMPL_W-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bit_cnt     <= BitW'(FrameBits - 1);
      r_lrclk       <= 1'b0;
      r_sdata       <= 1'b0;
      r_hold_l      <= '0;
      r_hold_r      <= '0;
      r_fresh_l     <= 1'b0;
      r_fresh_r     <= 1'b0;
      r_shift_l     <= '0;
      r_shift_r     <= '0;
      r_lsb_l       <= 1'b0;
      r_lsb_r       <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_frame_start <= w_load;
      r_underrun    <= w_load & ~(r_fresh_l & r_fresh_r);
      r_overrun     <= (w_wr_l & r_fresh_l) | (w_wr_r & r_fresh_r) | (i_din_valid == 2'b11);

      if (w_wr_l) r_hold_l <= i_din;
      if (w_wr_r) r_hold_r <= i_din;

      // A write coinciding with the load belongs to the next frame, so it keeps fresh set.
      if (w_wr_l)      r_fresh_l <= 1'b1;
      else if (w_load) r_fresh_l <= 1'b0;
      if (w_wr_r)      r_fresh_r <= 1'b1;
      else if (w_load) r_fresh_r <= 1'b0;

      if (w_fall) begin
        r_bit_cnt <= w_bit_nxt;
        r_lrclk   <= (w_chan_nxt == ChRight);
        r_sdata   <= w_sdata_nxt;
      end

      if (w_load) begin
        r_shift_l <= r_hold_l;
        r_shift_r <= r_hold_r;
        r_lsb_l   <= r_hold_l[0];
        r_lsb_r   <= r_hold_r[0];
      end else if (w_fall && w_in_word) begin
        if (w_chan_nxt == ChRight) r_shift_r <= {r_shift_r[SMPL_W-2:0], 1'b0};
        else                       r_shift_l <= {r_shift_l[SMPL_W-2:0], 1'b0};
      end
    end
  end

  assign o_lrclk       = r_lrclk;
  assign o_sdata       = r_sdata;
  assign o_frame_start = r_frame_start;
  assign o_underrun    = r_underrun;
  assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed + randomized bench for i2s_tx; expected outputs come from a model that
// derives the I2S waveform from the edge count since reset and per-frame words.
module tb_i2s_tx;

  localparam int unsigned CD   = 2;
  localparam int unsigned SW   = 24;
  localparam int unsigned SL   = 32;
  localparam int unsigned FRM  = 128 * CD;

  logic          clk;
  logic          rst;
  logic [1:0]    din_valid;
  logic [SW-1:0] din;
  logic          sclk, lrclk, sdata, frame_start, underrun, overrun;

  i2s_tx #(
    .CLK_DIV(CD),
    .SMPL_W (SW),
    .SLOT_W (SL)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_din_valid  (din_valid),
    .i_din        (din),
    .o_sclk       (sclk),
    .o_lrclk      (lrclk),
    .o_sdata      (sdata),
    .o_frame_start(frame_start),
    .o_underrun   (underrun),
    .o_overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int unsigned   n;
  logic [SW-1:0] m_hold_l, m_hold_r, m_cur_l, m_cur_r, m_prev_r;
  bit            m_fresh_l, m_fresh_r;
  logic          e_sclk, e_lrclk, e_sdata, e_fs, e_und, e_ovr;
  int            cnt_fs, cnt_und, cnt_ovr;

  function automatic bit is_load(input int unsigned x);
    return (x >= 2 * CD) && (((x - 2 * CD) % FRM) == 0);
  endfunction

  function automatic int cur_bit(input int unsigned x);
    int unsigned f;
    f = x / (2 * CD);
    return (f == 0) ? -1 : int'((f - 1) % (2 * SL));
  endfunction

  task automatic model_reset();
    n = 0;
    m_hold_l = '0; m_hold_r = '0; m_cur_l = '0; m_cur_r = '0; m_prev_r = '0;
    m_fresh_l = 0; m_fresh_r = 0;
    {e_sclk, e_lrclk, e_sdata, e_fs, e_und, e_ovr} = '0;
  endtask

  task automatic model_edge(input logic [1:0] v, input logic [SW-1:0] d);
    bit fl0, fr0, ld;
    int b, p;
    logic [SW-1:0] w;
    fl0 = m_fresh_l;
    fr0 = m_fresh_r;
    n++;
    ld = is_load(n);
    e_fs  = ld;
    e_und = ld && !(fl0 && fr0);
    if (ld) begin
      m_prev_r  = m_cur_r;
      m_cur_l   = m_hold_l;
      m_cur_r   = m_hold_r;
      m_fresh_l = 0;
      m_fresh_r = 0;
    end
    e_ovr = (v == 2'b11) || (v[0] && fl0) || (v == 2'b10 && fr0);
    if (v[0]) begin
      m_hold_l = d; m_fresh_l = 1;
    end else if (v == 2'b10) begin
      m_hold_r = d; m_fresh_r = 1;
    end
    e_sclk = ((n / CD) % 2) == 1;
    b = cur_bit(n);
    if (b < 0) begin
      e_lrclk = 1'b0;
      e_sdata = 1'b0;
    end else begin
      e_lrclk = (b >= int'(SL));
      p = b % int'(SL);
      w = e_lrclk ? m_cur_r : m_cur_l;
      if (p == 0)             e_sdata = e_lrclk ? m_cur_l[0] : m_prev_r[0];
      else if (p <= int'(SW)) e_sdata = w[5'(int'(SW) - p)];
      else                    e_sdata = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s at n=%0d observed=%b expected=%b", tag, n, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit r, input logic [1:0] v, input logic [SW-1:0] d);
    rst = r; din_valid = v; din = d;
    @(posedge clk);
    if (r) model_reset();
    else   model_edge(v, d);
    #1;
    chk("sclk", sclk, e_sclk);
    chk("lrclk", lrclk, e_lrclk);
    chk("sdata", sdata, e_sdata);
    chk("frame_start", frame_start, e_fs);
    chk("underrun", underrun, e_und);
    chk("overrun", overrun, e_ovr);
    if (frame_start === 1'b1) cnt_fs++;
    if (underrun === 1'b1)    cnt_und++;
    if (overrun === 1'b1)     cnt_ovr++;
    rst = 1'b0; din_valid = 2'b00; din = '0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick(0, 2'b00, '0);
  endtask

  // Idle until the frame load is exactly k edges away (k >= 1).
  task automatic advance_to(input int unsigned k);
    for (int i = 0; i < int'(FRM) + 8 && !is_load(n + k); i++) tick(0, 2'b00, '0);
  endtask

  int base_und, base_ovr, base_fs;

  initial begin
    rst = 1'b1; din_valid = 2'b00; din = '0;
    cnt_fs = 0; cnt_und = 0; cnt_ovr = 0;
    model_reset();

    // Reset held, then idle two frames: zeros on sdata, underrun with every frame start
    for (int i = 0; i < 3; i++) tick(1, 2'b00, '0);
    idle(520);
    chk_int("idle_frame_starts", cnt_fs, 3);
    chk_int("idle_underruns", cnt_und, 3);

    // Known patterns for both channels before a load
    advance_to(30);
    tick(0, 2'b01, 24'h800001);
    idle(3);
    tick(0, 2'b10, 24'h7FFFFE);
    base_und = cnt_und;
    advance_to(1);
    tick(0, 2'b00, '0);
    chk_int("pattern_no_underrun", cnt_und - base_und, 0);
    idle(300);

    // Two left strobes between loads: one overrun, newest sample transmitted
    advance_to(100);
    base_ovr = cnt_ovr;
    tick(0, 2'b01, 24'h000001);
    idle(5);
    tick(0, 2'b01, 24'hABCDEF);
    tick(0, 2'b10, 24'($urandom));
    chk_int("double_strobe_overrun", cnt_ovr - base_ovr, 1);
    idle(350);

    // Left strobe in the exact load cycle lands in the following frame
    advance_to(60);
    tick(0, 2'b01, 24'($urandom));
    tick(0, 2'b10, 24'($urandom));
    advance_to(1);
    tick(0, 2'b01, 24'($urandom));
    tick(0, 2'b10, 24'($urandom));
    base_und = cnt_und;
    base_fs  = cnt_fs;
    advance_to(1);
    tick(0, 2'b00, '0);
    chk_int("coincident_next_frame_start", cnt_fs - base_fs, 1);
    chk_int("coincident_next_no_underrun", cnt_und - base_und, 0);
    idle(100);

    // Right-only frame: underrun, left word repeated
    advance_to(80);
    tick(0, 2'b10, 24'($urandom));
    base_und = cnt_und;
    idle(300);
    chk_int("right_only_underrun", cnt_und - base_und, 1);

    // Randomized strobes, including occasional illegal 2'b11
    for (int i = 0; i < 6 * int'(FRM); i++) begin
      int unsigned r;
      r = $urandom_range(0, 79);
      if (r == 0)      tick(0, 2'b11, 24'($urandom));
      else if (r < 4)  tick(0, 2'b01, 24'($urandom));
      else if (r < 7)  tick(0, 2'b10, 24'($urandom));
      else             tick(0, 2'b00, '0);
    end

    // Reset mid-frame at bit_cnt 40, then restart as from power-up
    for (int i = 0; i < int'(FRM) + 8 && cur_bit(n) != 40; i++) tick(0, 2'b00, '0);
    chk_int("reached_bit40", cur_bit(n), 40);
    tick(1, 2'b00, '0);
    base_fs  = cnt_fs;
    base_und = cnt_und;
    idle(10);
    chk_int("post_reset_frame_start", cnt_fs - base_fs, 1);
    chk_int("post_reset_underrun", cnt_und - base_und, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
